// File: rtl/exec_unit_mc.sv
// Multi-cycle EX-stage execute unit: registered ALU, pipelined multiplier and
// iterative restoring divider behind a valid/ready handshake.
module exec_unit_mc #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       unit_sel,
    input  logic [3:0]       acl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    output logic             busy
);
    localparam int SHW     = $clog2(WIDTH);
    localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALU_WB,
        S_MUL_RUN,
        S_DIV_RUN,
        S_DIV_FIX,
        S_WB
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]         acl_q, acl_d;
    logic [1:0]         unit_q, unit_d;
    logic               corner_q, corner_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dres_q, dres_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d, out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] prod_q [MUL_STAGES];
    logic [2*WIDTH-1:0] prod_d [MUL_STAGES];

    logic [WIDTH-1:0]   alu_res, mul_res, wb_res;
    logic [SHW-1:0]     shamt;
    logic               mul_a_sgn, mul_b_sgn;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod_full;
    logic               div_sgn_in, div_zero_in, div_ovf_in, div_sgn_q, q_neg, r_neg;
    logic [WIDTH-1:0]   a_mag_in, b_mag, q_fix, r_fix;
    logic [WIDTH:0]     trial, diff;

    // ALU, evaluated from the latched operands during ALU_WB
    always_comb begin
        alu_res = '0;
        shamt   = b_q[SHW-1:0];
        if (unit_q == 2'd3) begin
            alu_res = a_q + b_q;
        end else begin
            case (acl_q)
                4'b0000: alu_res = a_q & b_q;
                4'b0001: alu_res = a_q | b_q;
                4'b0010: alu_res = a_q + b_q;
                4'b0110: alu_res = a_q - b_q;
                4'b1000: alu_res = a_q ^ b_q;
                4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                4'b1100: alu_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
                4'b1001: alu_res = a_q << shamt;
                4'b1010: alu_res = a_q >> shamt;
                4'b1011: alu_res = $signed(a_q) >>> shamt;
                default: alu_res = '0;
            endcase
        end
    end

    // Multiplier: operands are sign- or zero-extended to 2*WIDTH, so one
    // modular product serves every signedness combination.
    always_comb begin
        mul_a_sgn = (acl_q[1:0] != 2'b11);
        mul_b_sgn = ~acl_q[1];
        a_ext     = {{WIDTH{mul_a_sgn & a_q[WIDTH-1]}}, a_q};
        b_ext     = {{WIDTH{mul_b_sgn & b_q[WIDTH-1]}}, b_q};
        prod_full = a_ext * b_ext;
        prod_d[0] = prod_full;
        for (int i = 1; i < MUL_STAGES; i++) begin
            prod_d[i] = prod_q[i-1];
        end
        mul_res = (acl_q[1:0] == 2'b00) ? prod_q[MUL_STAGES-1][WIDTH-1:0]
                                        : prod_q[MUL_STAGES-1][2*WIDTH-1:WIDTH];
    end

    // Divider operand conditioning, corner detection and sign fix-up
    always_comb begin
        div_sgn_in  = ~acl[0];
        a_mag_in    = (div_sgn_in & a[WIDTH-1]) ? -a : a;
        div_zero_in = (b == '0);
        div_ovf_in  = div_sgn_in && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
        div_sgn_q   = ~acl_q[0];
        b_mag       = (div_sgn_q & b_q[WIDTH-1]) ? -b_q : b_q;
        q_neg       = div_sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg       = div_sgn_q & a_q[WIDTH-1];
        q_fix       = q_neg ? -quo_q : quo_q;
        r_fix       = r_neg ? -rem_q : rem_q;
        trial       = {rem_q, quo_q[WIDTH-1]};
        diff        = trial - {1'b0, b_mag};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acl_d       = acl_q;
        unit_d      = unit_q;
        corner_d    = corner_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dres_d      = dres_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        wb_res      = (unit_q == 2'd1) ? mul_res : dres_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    acl_d  = acl;
                    unit_d = unit_sel;
                    case (unit_sel)
                        2'd1: begin
                            state_d = S_MUL_RUN;
                            cnt_d   = CW'(MUL_STAGES - 1);
                        end
                        2'd2: begin
                            corner_d = div_zero_in | div_ovf_in;
                            rem_d    = '0;
                            quo_d    = a_mag_in;
                            cnt_d    = CW'(WIDTH);
                            if (div_zero_in | div_ovf_in) state_d = S_DIV_FIX;
                            else                          state_d = S_DIV_RUN;
                        end
                        default: state_d = S_ALU_WB;
                    endcase
                end
            end
            S_ALU_WB: begin
                result_d    = alu_res;
                zero_d      = (alu_res == '0);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_MUL_RUN: begin
                if (cnt_q == '0) state_d = S_WB;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_DIV_RUN: begin
                // One restoring step: keep the trial difference when it does not borrow
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                if (corner_q) begin
                    if (b_q == '0) dres_d = acl_q[1] ? a_q : '1;
                    else           dres_d = acl_q[1] ? '0 : a_q;
                end else begin
                    dres_d = acl_q[1] ? r_fix : q_fix;
                end
                state_d = S_WB;
            end
            S_WB: begin
                result_d    = wb_res;
                zero_d      = (wb_res == '0);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            result_d    = result_q;
            zero_d      = zero_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acl_q       <= '0;
            unit_q      <= '0;
            corner_q    <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dres_q      <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < MUL_STAGES; i++) prod_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acl_q       <= acl_d;
            unit_q      <= unit_d;
            corner_q    <= corner_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dres_q      <= dres_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < MUL_STAGES; i++) prod_q[i] <= prod_d[i];
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = ~in_ready;
    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_exec_unit_mc.sv
// Randomised bench for exec_unit_mc against an arithmetic reference model,
// covering a 32-bit/2-stage instance and a 16-bit/1-stage instance.
module tb_exec_unit_mc;
    logic        clk = 1'b0;
    logic        rst, flush, v32, v16;
    logic [1:0]  u;
    logic [3:0]  op;
    logic [31:0] x, y;
    logic        rdy32, ov32, z32, bsy32;
    logic [31:0] res32;
    logic        rdy16, ov16, z16, bsy16;
    logic [15:0] res16;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    exec_unit_mc #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(v32), .in_ready(rdy32),
        .unit_sel(u), .acl(op), .a(x), .b(y), .result(res32), .zero(z32),
        .out_valid(ov32), .busy(bsy32)
    );

    exec_unit_mc #(.WIDTH(16), .MUL_STAGES(1)) dut16 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(v16), .in_ready(rdy16),
        .unit_sel(u), .acl(op), .a(x[15:0]), .b(y[15:0]), .result(res16), .zero(z16),
        .out_valid(ov16), .busy(bsy16)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_rdy(input int which);
        return (which != 0) ? rdy16 : rdy32;
    endfunction
    function automatic logic cur_ov(input int which);
        return (which != 0) ? ov16 : ov32;
    endfunction
    function automatic logic cur_bsy(input int which);
        return (which != 0) ? bsy16 : bsy32;
    endfunction
    function automatic logic cur_zero(input int which);
        return (which != 0) ? z16 : z32;
    endfunction
    function automatic logic [63:0] cur_res(input int which);
        return (which != 0) ? {48'd0, res16} : {32'd0, res32};
    endfunction

    // Reference: plain integer arithmetic on w-bit values held in 64 bits
    function automatic logic [63:0] model(input int w, input logic [1:0] uu, input logic [3:0] oo,
                                          input logic [63:0] xv, input logic [63:0] yv);
        logic [63:0]  m, sxb, syb, r;
        longint       sx, sy, smin;
        logic [127:0] px, py, p;
        int           sh;
        m    = (64'd1 << w) - 64'd1;
        sxb  = xv[w-1] ? (xv | ~m) : xv;
        syb  = yv[w-1] ? (yv | ~m) : yv;
        sx   = longint'(sxb);
        sy   = longint'(syb);
        smin = -(longint'(1) <<< (w - 1));
        sh   = int'(yv % 64'(w));
        r    = 64'd0;
        if (uu == 2'd1) begin
            px = (oo[1:0] != 2'b11) ? {{64{sxb[63]}}, sxb} : {64'd0, xv};
            py = (oo[1] == 1'b0)    ? {{64{syb[63]}}, syb} : {64'd0, yv};
            p  = px * py;
            r  = (oo[1:0] == 2'b00) ? p[63:0] : 64'(p >> w);
        end else if (uu == 2'd2) begin
            if (yv == 64'd0)                              r = oo[1] ? xv : m;
            else if (!oo[0] && sx == smin && sy == -64'sd1) r = oo[1] ? 64'd0 : xv;
            else if (!oo[0])                              r = oo[1] ? 64'(sx % sy) : 64'(sx / sy);
            else                                          r = oo[1] ? (xv % yv) : (xv / yv);
        end else if (uu == 2'd3) begin
            r = xv + yv;
        end else begin
            case (oo)
                4'b0000: r = xv & yv;
                4'b0001: r = xv | yv;
                4'b0010: r = xv + yv;
                4'b0110: r = xv - yv;
                4'b1000: r = xv ^ yv;
                4'b0111: r = (sx < sy) ? 64'd1 : 64'd0;
                4'b1100: r = (xv < yv) ? 64'd1 : 64'd0;
                4'b1001: r = xv << sh;
                4'b1010: r = xv >> sh;
                4'b1011: r = 64'(sx >>> sh);
                default: r = 64'd0;
            endcase
        end
        return r & m;
    endfunction

    task automatic run_op(input int which, input logic [1:0] uu, input logic [3:0] oo,
                          input logic [31:0] xa, input logic [31:0] yb, output logic [63:0] got);
        int          w, ms, lat, exp_lat;
        logic [63:0] m, xv, yv, exp;
        bit          stay_busy;
        w  = (which != 0) ? 16 : 32;
        ms = (which != 0) ? 1 : 2;
        m  = (64'd1 << w) - 64'd1;
        xv = 64'(xa) & m;
        yv = 64'(yb) & m;
        exp = model(w, uu, oo, xv, yv);
        if (uu == 2'd1) exp_lat = ms + 1;
        else if (uu == 2'd2) begin
            if (yv == 64'd0 || (!oo[0] && xv == (64'd1 << (w - 1)) && yv == m)) exp_lat = 2;
            else exp_lat = w + 2;
        end else exp_lat = 1;

        @(negedge clk);
        check_val("ready_before_issue", 64'(cur_rdy(which)), 64'd1);
        u = uu; op = oo; x = xa; y = yb;
        if (which != 0) v16 = 1'b1; else v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; v16 = 1'b0;
        stay_busy = 1'b1;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            if (cur_rdy(which) || !cur_bsy(which)) stay_busy = 1'b0;
            @(posedge clk); #1;
            if (cur_ov(which)) begin
                lat = i;
                break;
            end
        end
        got = cur_res(which);
        check_val("latency", 64'(lat), 64'(exp_lat));
        check_val("result", got, exp);
        check_val("zero", 64'(cur_zero(which)), 64'(exp == 64'd0));
        check_val("busy_while_running", 64'(stay_busy), 64'd1);
        check_val("ready_at_done", 64'(cur_rdy(which)), 64'd1);
        $display("op w=%0d unit=%0d acl=%b a=0x%0h b=0x%0h -> 0x%0h (want 0x%0h) lat=%0d",
                 w, uu, oo, xv, yv, got, exp, lat);
        @(posedge clk); #1;
        check_val("single_strobe", 64'(cur_ov(which)), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_8000;
            5:       return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [63:0] saved;
        bit          seen;
        rst = 1'b1; flush = 1'b0; v32 = 1'b0; v16 = 1'b0;
        u = 2'd0; op = 4'd0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_result", 64'(res32), 64'd0);
        check_val("rst_zero", 64'(z32), 64'd1);
        check_val("rst_out_valid", 64'(ov32), 64'd0);
        check_val("rst_in_ready", 64'(rdy32), 64'd1);
        check_val("rst_busy", 64'(bsy32), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 2'd0, 4'b0010, 32'd7, -32'd7, r);              check_val("add_7_m7", r, 64'h0);
        run_op(0, 2'd0, 4'b0110, 32'd5, 32'd9, r);               check_val("sub_5_9", r, 64'hFFFF_FFFC);
        run_op(0, 2'd0, 4'b1011, 32'h8000_0000, 32'd4, r);       check_val("sra", r, 64'hF800_0000);
        run_op(0, 2'd0, 4'b1100, 32'd1, 32'hFFFF_FFFF, r);       check_val("sltu", r, 64'h1);
        run_op(0, 2'd1, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r); check_val("mul", r, 64'h1);
        run_op(0, 2'd1, 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r); check_val("mulh", r, 64'h0);
        run_op(0, 2'd1, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r); check_val("mulhu", r, 64'hFFFF_FFFE);
        run_op(0, 2'd1, 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r); check_val("mulhsu", r, 64'hFFFF_FFFF);
        run_op(0, 2'd2, 4'b0000, -32'd20, 32'd6, r);             check_val("div", r, 64'hFFFF_FFFD);
        run_op(0, 2'd2, 4'b0010, -32'd20, 32'd6, r);             check_val("rem", r, 64'hFFFF_FFFE);
        run_op(0, 2'd2, 4'b0001, 32'd100, 32'd7, r);             check_val("divu", r, 64'd14);
        run_op(0, 2'd2, 4'b0011, 32'd100, 32'd7, r);             check_val("remu", r, 64'd2);
        run_op(0, 2'd2, 4'b0000, 32'd5, 32'd0, r);               check_val("div_by0", r, 64'hFFFF_FFFF);
        run_op(0, 2'd2, 4'b0010, 32'd5, 32'd0, r);               check_val("rem_by0", r, 64'd5);
        run_op(0, 2'd2, 4'b0000, 32'h8000_0000, 32'hFFFF_FFFF, r); check_val("div_ovf", r, 64'h8000_0000);
        run_op(0, 2'd2, 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, r); check_val("rem_ovf", r, 64'h0);
        run_op(0, 2'd3, 4'b1111, 32'd40, 32'd2, r);              check_val("reserved_add", r, 64'd42);

        // Flush about ten cycles into a divide
        run_op(0, 2'd0, 4'b0001, 32'h1200, 32'h0034, saved);
        @(negedge clk);
        u = 2'd2; op = 4'b0001; x = 32'd1000; y = 32'd7; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_val("flush_ready", 64'(rdy32), 64'd1);
        check_val("flush_no_valid", 64'(ov32), 64'd0);
        check_val("flush_result_kept", 64'(res32), saved);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov32) seen = 1'b1;
        end
        check_val("flush_no_strobe", 64'(seen), 64'd0);
        run_op(0, 2'd0, 4'b0010, 32'd2, 32'd3, r);               check_val("add_after_flush", r, 64'd5);

        // Flush on the same edge as an accept drops the request
        @(negedge clk);
        u = 2'd0; op = 4'b0010; x = 32'd1; y = 32'd1; v32 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; flush = 1'b0;
        check_val("flush_accept_ready", 64'(rdy32), 64'd1);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ov32) seen = 1'b1;
        end
        check_val("flush_accept_no_strobe", 64'(seen), 64'd0);
        check_val("flush_accept_result", 64'(res32), 64'd5);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        u = 2'd1; op = 4'b0000; x = 32'd3; y = 32'd4; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mid_rst_result", 64'(res32), 64'd0);
        check_val("mid_rst_zero", 64'(z32), 64'd1);
        check_val("mid_rst_ready", 64'(rdy32), 64'd1);
        check_val("mid_rst_valid", 64'(ov32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov32) seen = 1'b1;
        end
        check_val("mid_rst_no_strobe", 64'(seen), 64'd0);

        // 16-bit, single-stage multiplier instance
        run_op(1, 2'd1, 4'b0011, 32'h0000_FFFF, 32'h0000_FFFF, r); check_val("mulhu16", r, 64'hFFFE);
        run_op(1, 2'd2, 4'b0000, 32'h0000_8000, 32'h0000_FFFF, r); check_val("div16_ovf", r, 64'h8000);

        for (int k = 0; k < 30; k++) begin
            run_op(0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), pick(), pick(), r);
        end
        for (int k = 0; k < 12; k++) begin
            run_op(1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), pick(), pick(), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
